// File: rtl/tmds_channel_decoder.sv
// rtl/tmds_channel_decoder.sv - TMDS channel receiver: bit-slip alignment, lock monitor, symbol decode
module tmds_channel_decoder #(
    parameter int CTRL_RUN_LOCK = 4,
    parameter int SEARCH_DWELL  = 1024,
    parameter int LOCK_TIMEOUT  = 2048
) (
    input  logic       clk_pixel,
    input  logic       rst,
    input  logic [9:0] raw_word,
    output logic       de,
    output logic [1:0] ctrl,
    output logic [7:0] data,
    output logic       locked,
    output logic [3:0] slip_offset,
    output logic       sym_ctrl
);
    localparam int RUN_W   = $clog2(CTRL_RUN_LOCK + 1);
    localparam int DWELL_W = $clog2(SEARCH_DWELL);
    localparam int TMO_W   = $clog2(LOCK_TIMEOUT);

    localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(CTRL_RUN_LOCK - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SEARCH_DWELL - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(LOCK_TIMEOUT - 1);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t             state, state_n;
    logic [9:0]         prev_word;
    logic [9:0]         sym;
    logic [RUN_W-1:0]   run_cnt, run_n;
    logic [DWELL_W-1:0] dwell_cnt, dwell_n;
    logic [TMO_W-1:0]   timeout_cnt, tmo_n;
    logic [3:0]         slip_n;
    logic               is_tok;
    logic [1:0]         tok_val;
    logic [7:0]         d_raw, dec;
    logic               de_n, sym_ctrl_n, locked_n;
    logic [1:0]         ctrl_n;
    logic [7:0]         data_n;

    // Earlier bits live in prev_word, so the window slides toward later bits as the offset grows
    assign sym = 10'({raw_word, prev_word} >> slip_offset);

    always_comb begin
        is_tok  = 1'b1;
        tok_val = 2'b00;
        case (sym)
            10'b1101010100: tok_val = 2'b00;
            10'b0010101011: tok_val = 2'b01;
            10'b0101010100: tok_val = 2'b10;
            10'b1010101011: tok_val = 2'b11;
            default:        is_tok  = 1'b0;
        endcase
    end

    always_comb begin
        d_raw  = sym[9] ? ~sym[7:0] : sym[7:0];
        dec    = 8'h00;
        dec[0] = d_raw[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = sym[8] ? (d_raw[i] ^ d_raw[i-1]) : ~(d_raw[i] ^ d_raw[i-1]);
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            state       <= SEARCH;
            prev_word   <= 10'd0;
            slip_offset <= 4'd0;
            run_cnt     <= '0;
            dwell_cnt   <= '0;
            timeout_cnt <= '0;
            de          <= 1'b0;
            ctrl        <= 2'b00;
            data        <= 8'h00;
            locked      <= 1'b0;
            sym_ctrl    <= 1'b0;
        end else begin
            state       <= state_n;
            prev_word   <= raw_word;
            slip_offset <= slip_n;
            run_cnt     <= run_n;
            dwell_cnt   <= dwell_n;
            timeout_cnt <= tmo_n;
            de          <= de_n;
            ctrl        <= ctrl_n;
            data        <= data_n;
            locked      <= locked_n;
            sym_ctrl    <= sym_ctrl_n;
        end
    end

    always_comb begin
        state_n = state;
        slip_n  = slip_offset;
        run_n   = run_cnt;
        dwell_n = dwell_cnt;
        tmo_n   = timeout_cnt;
        case (state)
            SEARCH: begin
                tmo_n = '0;
                // A completed run takes priority over dwell expiry on the same cycle
                if (is_tok && run_cnt == RUN_LAST) begin
                    state_n = LOCKED;
                    run_n   = '0;
                    dwell_n = '0;
                end else if (dwell_cnt == DWELL_LAST) begin
                    slip_n  = (slip_offset == 4'd9) ? 4'd0 : slip_offset + 4'd1;
                    dwell_n = '0;
                    run_n   = '0;
                end else begin
                    dwell_n = dwell_cnt + 1'b1;
                    run_n   = is_tok ? run_cnt + 1'b1 : '0;
                end
            end
            LOCKED: begin
                if (is_tok) begin
                    tmo_n = '0;
                end else if (timeout_cnt == TMO_LAST) begin
                    state_n = SEARCH;
                    tmo_n   = '0;
                    run_n   = '0;
                    dwell_n = '0;
                end else begin
                    tmo_n = timeout_cnt + 1'b1;
                end
            end
            default: state_n = SEARCH;
        endcase
    end

    always_comb begin
        de_n       = de;
        ctrl_n     = ctrl;
        data_n     = data;
        locked_n   = locked;
        sym_ctrl_n = 1'b0;
        if (state == SEARCH) begin
            de_n     = 1'b0;
            data_n   = 8'h00;
            ctrl_n   = 2'b00;
            locked_n = 1'b0;
            if (state_n == LOCKED) begin
                locked_n   = 1'b1;
                ctrl_n     = tok_val;
                sym_ctrl_n = 1'b1;
            end
        end else if (is_tok) begin
            de_n       = 1'b0;
            ctrl_n     = tok_val;
            sym_ctrl_n = 1'b1;
            locked_n   = 1'b1;
        end else if (state_n == SEARCH) begin
            de_n     = 1'b0;
            data_n   = 8'h00;
            ctrl_n   = 2'b00;
            locked_n = 1'b0;
        end else begin
            de_n     = 1'b1;
            data_n   = dec;
            locked_n = 1'b1;
        end
    end
endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb/tb_tmds_channel_decoder.sv - scoreboard bench for tmds_channel_decoder
module tb_tmds_channel_decoder;
    localparam int RUN   = 4;
    localparam int DWELL = 1024;
    localparam int TMO   = 2048;

    localparam logic [9:0] T0 = 10'b1101010100;
    localparam logic [9:0] T1 = 10'b0010101011;
    localparam logic [9:0] T2 = 10'b0101010100;
    localparam logic [9:0] T3 = 10'b1010101011;

    logic       clk_pixel = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] raw_word = 10'd0;
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] data;
    logic       locked;
    logic [3:0] slip_offset;
    logic       sym_ctrl;

    int errors = 0;
    int checks = 0;

    tmds_channel_decoder #(
        .CTRL_RUN_LOCK(RUN),
        .SEARCH_DWELL(DWELL),
        .LOCK_TIMEOUT(TMO)
    ) dut (
        .clk_pixel(clk_pixel),
        .rst(rst),
        .raw_word(raw_word),
        .de(de),
        .ctrl(ctrl),
        .data(data),
        .locked(locked),
        .slip_offset(slip_offset),
        .sym_ctrl(sym_ctrl)
    );

    always #20 clk_pixel = ~clk_pixel;

    // Reference model state
    logic [9:0] m_prev = 10'd0;
    bit         m_lock_st = 1'b0;
    int         m_slip = 0, m_run = 0, m_dwell = 0, m_tmo = 0;
    logic       m_de = 1'b0, m_locked = 1'b0, m_symc = 1'b0;
    logic [1:0] m_ctrl = 2'b00;
    logic [7:0] m_data = 8'h00;

    // {de, ctrl, data, locked, slip, sym_ctrl}
    logic [16:0] sb[$];

    function automatic int tok_of(input logic [9:0] s);
        if (s == T0) return 0;
        if (s == T1) return 1;
        if (s == T2) return 2;
        if (s == T3) return 3;
        return -1;
    endfunction

    function automatic logic [7:0] dec_of(input logic [9:0] s);
        logic [7:0] d, r;
        d = s[9] ? ~s[7:0] : s[7:0];
        r[0] = d[0];
        for (int i = 1; i < 8; i++) r[i] = s[8] ? (d[i] ^ d[i-1]) : (d[i] ~^ d[i-1]);
        return r;
    endfunction

    task automatic model(input logic r, input logic [9:0] w);
        logic [19:0] cat;
        logic [9:0]  s;
        int          t;
        if (r) begin
            m_prev = 0; m_lock_st = 0; m_slip = 0; m_run = 0; m_dwell = 0; m_tmo = 0;
            m_de = 0; m_ctrl = 0; m_data = 0; m_locked = 0; m_symc = 0;
            return;
        end
        cat = {w, m_prev};
        s = cat[m_slip +: 10];
        t = tok_of(s);
        m_prev = w;
        m_symc = 0;
        if (!m_lock_st) begin
            m_de = 0; m_data = 0; m_ctrl = 0; m_locked = 0;
            m_run = (t >= 0) ? m_run + 1 : 0;
            m_dwell++;
            if (m_run == RUN) begin
                m_lock_st = 1; m_locked = 1; m_run = 0; m_dwell = 0;
                m_ctrl = 2'(t); m_symc = 1;
            end else if (m_dwell == DWELL) begin
                m_slip = (m_slip + 1) % 10; m_dwell = 0; m_run = 0;
            end
        end else if (t >= 0) begin
            m_de = 0; m_ctrl = 2'(t); m_symc = 1; m_tmo = 0;
        end else begin
            m_de = 1; m_data = dec_of(s); m_tmo++;
            if (m_tmo == TMO) begin
                m_lock_st = 0; m_locked = 0; m_de = 0; m_data = 0; m_ctrl = 0;
                m_tmo = 0; m_run = 0; m_dwell = 0;
            end
        end
    endtask

    task automatic step(input logic r, input logic [9:0] w);
        logic [16:0] got, exp_v;
        rst = r;
        raw_word = w;
        model(r, w);
        sb.push_back({m_de, m_ctrl, m_data, m_locked, 4'(m_slip), m_symc});
        @(posedge clk_pixel);
        #1;
        got = {de, ctrl, data, locked, slip_offset, sym_ctrl};
        exp_v = sb.pop_front();
        checks++;
        assert (got === exp_v) else begin
            errors++;
            $error("FAIL scoreboard t=%0t got de=%b ctrl=%b data=%h locked=%b slip=%0d symc=%b exp de=%b ctrl=%b data=%h locked=%b slip=%0d symc=%b",
                   $time, got[16], got[15:14], got[13:6], got[5], got[4:1], got[0],
                   exp_v[16], exp_v[15:14], exp_v[13:6], exp_v[5], exp_v[4:1], exp_v[0]);
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    logic [9:0] s1, w_rot;

    initial begin
        // Reset state
        step(1'b1, 10'd0);
        step(1'b1, 10'd0);
        chk("reset_locked", 16'(locked), 16'd0);
        chk("reset_outs", {de, ctrl, data, sym_ctrl}, 16'd0);

        // Aligned control tokens: lock on the 4th token edge
        for (int k = 1; k <= 6; k++) begin
            step(1'b0, T0);
            if (k == 4) chk("aligned_not_yet", 16'(locked), 16'd0);
            if (k == 5) chk("aligned_lock", 16'(locked), 16'd1);
        end
        chk("aligned_slip", 16'(slip_offset), 16'd0);
        chk("aligned_outs", {de, ctrl, sym_ctrl}, {12'd0, 1'b0, 2'b00, 1'b1});

        // Data decode and remaining control tokens
        step(1'b0, 10'h100);
        step(1'b0, 10'h2FF);
        chk("data_100", {de, ctrl, data}, {5'd0, 1'b1, 2'b00, 8'h00});
        step(1'b0, T2);
        chk("data_2ff", {de, ctrl, data}, {5'd0, 1'b1, 2'b00, 8'hFE});
        step(1'b0, T3);
        chk("ctrl_10", {de, ctrl, data}, {5'd0, 1'b0, 2'b10, 8'hFE});
        step(1'b0, T3);
        chk("ctrl_11", {de, ctrl, data}, {5'd0, 1'b0, 2'b11, 8'hFE});

        // Lock loss after 2048 non-control symbols
        for (int k = 1; k <= 2049; k++) begin
            step(1'b0, 10'h100);
            if (k == 2048) chk("timeout_held", 16'(locked), 16'd1);
        end
        chk("timeout_drop", {locked, de, data}, 16'd0);
        chk("timeout_slip", 16'(slip_offset), 16'd0);
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, T1);
            if (k == 4) chk("relock_not_yet", 16'(locked), 16'd0);
        end
        chk("relock", {locked, ctrl}, {13'd0, 1'b1, 2'b01});

        // Misaligned stream: word rotated by 3 bits, search must step to offset 3
        s1 = T1;
        w_rot = {s1[6:0], s1[9:7]};
        step(1'b1, 10'd0);
        for (int k = 1; k <= 3076; k++) begin
            step(1'b0, w_rot);
            if (k == 1023) chk("slip_pre1", 16'(slip_offset), 16'd0);
            if (k == 1024) chk("slip_1", 16'(slip_offset), 16'd1);
            if (k == 2047) chk("slip_pre2", 16'(slip_offset), 16'd1);
            if (k == 2048) chk("slip_2", 16'(slip_offset), 16'd2);
            if (k == 3072) chk("slip_3", 16'(slip_offset), 16'd3);
            if (k == 3075) chk("mis_not_yet", 16'(locked), 16'd0);
        end
        chk("mis_lock", {locked, slip_offset, ctrl}, {9'd0, 1'b1, 4'd3, 2'b01});
        step(1'b0, w_rot);
        step(1'b0, w_rot);

        // Reset while locked at offset 3
        step(1'b1, w_rot);
        chk("midreset", {locked, slip_offset, de, ctrl, data}, 16'd0);
        step(1'b0, w_rot);
        step(1'b0, w_rot);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
